proc_control_unit: RTL and testbench

Multi-cycle sequencer for the 16-bit processor datapath (8x16 register bank, ALU with G/A registers, 8-entry data memory, 16-entry instruction memory). It fetches the instruction addressed by pc and latches it internally. It then decodes the 4-bit opcode and drives one-hot register-bank enables, ALU/memory strobes and the Done pulse, step by step (T0..T3). It replaces the inline case-per-stage sequencing inside the processor: the datapath only obeys strobes.

---
 rtl/proc_control_unit.sv | 143 ++++++++++++++
 tb/tb_proc_control_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
// proc_control_unit: multi-cycle T0..T3 sequencer that fetches, latches and decodes instructions into datapath strobes
module proc_control_unit #(
    parameter int PCW  = 4,
    parameter int NREG = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Run,
    input  logic [15:0]             IR,
    input  logic                    Gnz,
    output logic [PCW-1:0]          pc,
    output logic [1:0]              curr_stage,
    output logic [$clog2(NREG)-1:0] reg_A,
    output logic [$clog2(NREG)-1:0] reg_B,
    output logic                    IRin,
    output logic [NREG-1:0]         Rin,
    output logic [NREG-1:0]         Rout,
    output logic                    ImmOut,
    output logic                    Ain,
    output logic                    Gin,
    output logic                    Gout,
    output logic [2:0]              AluOp,
    output logic                    AddrIn,
    output logic                    MemRd,
    output logic                    MemOut,
    output logic                    MemWr,
    output logic                    Done,
    output logic                    Illegal
);
    localparam int RW = $clog2(NREG);

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;

    step_t           step, step_nx;
    logic [15:0]     ir_q;
    logic [3:0]      op;
    logic [NREG-1:0] a_oh, b_oh;
    logic            en;

    assign op         = ir_q[15:12];
    assign reg_A      = ir_q[9 +: RW];
    assign reg_B      = ir_q[6 +: RW];
    assign a_oh       = NREG'(1) << reg_A;
    assign b_oh       = NREG'(1) << reg_B;
    assign curr_stage = step;
    // Strobes stay quiet while stalled or held in reset, even though step sits at T0 then.
    assign en         = Run & Reset;

    // Step, program counter and instruction latch; everything freezes while Run is low.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            step <= T0;
            pc   <= '0;
            ir_q <= '0;
        end else if (Run) begin
            step <= step_nx;
            if (step == T0) ir_q <= IR;
            if (Done) pc <= pc + 1'b1;
        end
    end

    // Decode of (step, latched opcode, Gnz) into strobes and the next step.
    always_comb begin
        IRin    = 1'b0;
        Rin     = '0;
        Rout    = '0;
        ImmOut  = 1'b0;
        Ain     = 1'b0;
        Gin     = 1'b0;
        Gout    = 1'b0;
        AluOp   = 3'b000;
        AddrIn  = 1'b0;
        MemRd   = 1'b0;
        MemOut  = 1'b0;
        MemWr   = 1'b0;
        Done    = 1'b0;
        Illegal = 1'b0;
        if (en) begin
            if (step == T0) begin
                IRin = 1'b1;
            end else begin
                case (op)
                    4'b0000: if (step == T1) begin
                        Rout = b_oh;
                        Rin  = a_oh;
                        Done = 1'b1;
                    end
                    4'b0001: if (step == T1) begin
                        ImmOut = 1'b1;
                        Rin    = a_oh;
                        Done   = 1'b1;
                    end
                    4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111: begin
                        if (step == T1) begin
                            Rout = a_oh;
                            Ain  = 1'b1;
                        end else if (step == T2) begin
                            Rout  = b_oh;
                            Gin   = 1'b1;
                            AluOp = 3'(op - 4'd2);
                        end else begin
                            Gout = 1'b1;
                            Rin  = a_oh;
                            Done = 1'b1;
                        end
                    end
                    4'b1000: if (step == T1) begin
                        Rout = Gnz ? b_oh : '0;
                        Rin  = Gnz ? a_oh : '0;
                        Done = 1'b1;
                    end
                    4'b1001: begin
                        if (step == T1) begin
                            Rout   = b_oh;
                            AddrIn = 1'b1;
                        end else if (step == T2) begin
                            MemRd = 1'b1;
                        end else begin
                            MemOut = 1'b1;
                            Rin    = a_oh;
                            Done   = 1'b1;
                        end
                    end
                    4'b1010: begin
                        if (step == T1) begin
                            Rout   = b_oh;
                            AddrIn = 1'b1;
                        end else begin
                            Rout  = a_oh;
                            MemWr = 1'b1;
                            Done  = 1'b1;
                        end
                    end
                    default: if (step == T1) begin
                        Done    = 1'b1;
                        Illegal = 1'b1;
                    end
                endcase
            end
        end
        step_nx = Done ? T0 : step_t'(step + 2'd1);
    end
endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit: directed program run with a scoreboard of expected per-cycle strobe vectors
module tb_proc_control_unit;
    typedef struct packed {
        logic [3:0] pc;
        logic [1:0] st;
        logic       irin;
        logic [7:0] rin;
        logic [7:0] rout;
        logic       imm, ain, gin, gout;
        logic [2:0] aluop;
        logic       addrin, memrd, memout, memwr, done, ill;
    } out_t;

    typedef struct {
        string tag;
        out_t  e;
    } sb_t;

    localparam logic [10:0] IRIN = 11'h400, IMM = 11'h200, AIN = 11'h100, GIN = 11'h080;
    localparam logic [10:0] GOUT = 11'h040, ADDR = 11'h020, RD = 11'h010, MO = 11'h008;
    localparam logic [10:0] WR = 11'h004, DN = 11'h002, IL = 11'h001, NONE = 11'h000;

    logic        Clock, Reset, Run, Gnz;
    logic [15:0] IR;
    logic [3:0]  pc;
    logic [1:0]  curr_stage;
    logic [2:0]  reg_A, reg_B, AluOp;
    logic [7:0]  Rin, Rout;
    logic        IRin, ImmOut, Ain, Gin, Gout, AddrIn, MemRd, MemOut, MemWr, Done, Illegal;
    logic [15:0] imem [16];
    out_t        obs;
    sb_t         q[$];
    int          checks = 0;
    int          errors = 0;

    proc_control_unit #(.PCW(4), .NREG(8)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .Gnz(Gnz),
        .pc(pc), .curr_stage(curr_stage), .reg_A(reg_A), .reg_B(reg_B),
        .IRin(IRin), .Rin(Rin), .Rout(Rout), .ImmOut(ImmOut), .Ain(Ain),
        .Gin(Gin), .Gout(Gout), .AluOp(AluOp), .AddrIn(AddrIn), .MemRd(MemRd),
        .MemOut(MemOut), .MemWr(MemWr), .Done(Done), .Illegal(Illegal)
    );

    assign IR  = imem[pc];
    assign obs = {pc, curr_stage, IRin, Rin, Rout, ImmOut, Ain, Gin, Gout,
                  AluOp, AddrIn, MemRd, MemOut, MemWr, Done, Illegal};

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of run, expected finish before 100000");
        $fatal(1, "timeout");
    end

    function automatic out_t mk(input logic [3:0] p, input logic [1:0] s, input logic [7:0] rin,
                                input logic [7:0] rout, input logic [2:0] alu, input logic [10:0] f);
        out_t e;
        e       = '0;
        e.pc    = p;
        e.st    = s;
        e.rin   = rin;
        e.rout  = rout;
        e.aluop = alu;
        {e.irin, e.imm, e.ain, e.gin, e.gout, e.addrin, e.memrd, e.memout, e.memwr, e.done, e.ill} = f;
        return e;
    endfunction

    function automatic out_t t0(input logic [3:0] p);
        return mk(p, 2'd0, 8'h00, 8'h00, 3'd0, IRIN);
    endfunction

    task automatic pop_cmp();
        sb_t s;
        s = q.pop_front();
        checks++;
        assert (obs === s.e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", s.tag, obs, s.e);
        end
    endtask

    task automatic chk_now(input string tag, input out_t e);
        q.push_back('{tag, e});
        #1;
        pop_cmp();
    endtask

    task automatic chk_here(input string tag, input out_t e);
        q.push_back('{tag, e});
        @(negedge Clock);
        pop_cmp();
    endtask

    task automatic chk(input string tag, input out_t e);
        chk_here(tag, e);
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] a, input logic [2:0] b);
        checks++;
        assert ({reg_A, reg_B} === {a, b}) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, {reg_A, reg_B}, {a, b});
        end
    endtask

    initial begin
        imem[0] = 16'h24C0;
        imem[1] = 16'h1405;
        imem[2] = 16'h9100;
        imem[3] = 16'hA640;
        imem[4] = 16'h8B80;
        imem[5] = 16'h83C0;
        imem[6] = 16'hC000;
        imem[7] = 16'h3840;
        for (int i = 8; i < 15; i++) imem[i] = 16'h0280;
        imem[15] = 16'h7F80;
        Reset = 1'b0;
        Run   = 1'b1;
        Gnz   = 1'b0;
        chk_now("reset_idle", mk(4'd0, 2'd0, 8'h00, 8'h00, 3'd0, NONE));
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        chk("add_T0", t0(4'd0));
        chk("add_T1", mk(4'd0, 2'd1, 8'h00, 8'h04, 3'd0, AIN));
        chk_here("add_T2", mk(4'd0, 2'd2, 8'h00, 8'h08, 3'd0, GIN));
        #1;
        Reset = 1'b0;
        chk_now("async_reset", mk(4'd0, 2'd0, 8'h00, 8'h00, 3'd0, NONE));
        chk_reg("reset_regs", 3'd0, 3'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        chk("add2_T0", t0(4'd0));
        chk("add2_T1", mk(4'd0, 2'd1, 8'h00, 8'h04, 3'd0, AIN));
        chk("add2_T2", mk(4'd0, 2'd2, 8'h00, 8'h08, 3'd0, GIN));
        chk("add2_T3", mk(4'd0, 2'd3, 8'h04, 8'h00, 3'd0, GOUT | DN));
        chk("mvi_T0", t0(4'd1));
        chk("mvi_T1", mk(4'd1, 2'd1, 8'h04, 8'h00, 3'd0, IMM | DN));
        chk_reg("mvi_regs", 3'd2, 3'd0);
        chk("ld_T0", t0(4'd2));
        chk("ld_T1", mk(4'd2, 2'd1, 8'h00, 8'h10, 3'd0, ADDR));
        chk("ld_T2", mk(4'd2, 2'd2, 8'h00, 8'h00, 3'd0, RD));
        chk("ld_T3", mk(4'd2, 2'd3, 8'h01, 8'h00, 3'd0, MO | DN));
        chk("sd_T0", t0(4'd3));
        chk("sd_T1", mk(4'd3, 2'd1, 8'h00, 8'h02, 3'd0, ADDR));
        chk("sd_T2", mk(4'd3, 2'd2, 8'h00, 8'h08, 3'd0, WR | DN));
        chk_reg("sd_regs", 3'd3, 3'd1);
        chk("mvnz0_T0", t0(4'd4));
        chk("mvnz0_T1", mk(4'd4, 2'd1, 8'h00, 8'h00, 3'd0, DN));
        chk("mvnz1_T0", t0(4'd5));
        Gnz = 1'b1;
        chk("mvnz1_T1", mk(4'd5, 2'd1, 8'h02, 8'h80, 3'd0, DN));
        Gnz = 1'b0;
        chk("ill_T0", t0(4'd6));
        chk("ill_T1", mk(4'd6, 2'd1, 8'h00, 8'h00, 3'd0, DN | IL));
        chk("sub_T0", t0(4'd7));
        chk("sub_T1", mk(4'd7, 2'd1, 8'h00, 8'h10, 3'd0, AIN));
        Run = 1'b0;
        for (int i = 0; i < 3; i++) chk("sub_stall", mk(4'd7, 2'd2, 8'h00, 8'h00, 3'd0, NONE));
        Run = 1'b1;
        chk("sub_T2", mk(4'd7, 2'd2, 8'h00, 8'h02, 3'd1, GIN));
        chk("sub_T3", mk(4'd7, 2'd3, 8'h10, 8'h00, 3'd0, GOUT | DN));
        for (int i = 8; i < 15; i++) begin
            chk("mv_T0", t0(4'(i)));
            chk("mv_T1", mk(4'(i), 2'd1, 8'h02, 8'h04, 3'd0, DN));
        end
        chk("srl_T0", t0(4'd15));
        chk("srl_T1", mk(4'd15, 2'd1, 8'h00, 8'h80, 3'd0, AIN));
        chk("srl_T2", mk(4'd15, 2'd2, 8'h00, 8'h40, 3'd5, GIN));
        chk("srl_T3", mk(4'd15, 2'd3, 8'h80, 8'h00, 3'd0, GOUT | DN));
        chk("wrap_T0", t0(4'd0));
        chk("wrap_T1", mk(4'd0, 2'd1, 8'h00, 8'h04, 3'd0, AIN));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
